// File: rtl/sub64_share_arb.sv
// Two-port arbiter/sequencer for the shared SUB64 subtractor, with lock ownership and a lock watchdog.
// Define SUB64_ARB_RESULT_REG_EN to register y0/y1 and their valid strobes (one cycle of result latency).
module sub64_share_arb #(
    parameter int unsigned MAX_LOCK = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic        lock0,
    input  logic        lock1,
    input  logic [63:0] a0,
    input  logic [63:0] b0,
    input  logic [63:0] a1,
    input  logic [63:0] b1,
    output logic        gnt0,
    output logic        gnt1,
    output logic [62:0] y0,
    output logic [62:0] y1,
    output logic        y0_valid,
    output logic        y1_valid,
    output logic        lock_err,
    output logic [63:0] sub_data_in_a,
    output logic [63:0] sub_data_in_b,
    output logic        sub_data_valid,
    input  logic [62:0] sub_data_out
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    localparam logic [5:0] MAX_LCNT = 6'(MAX_LOCK);

    state_t      state_q, state_d;
    logic        prio_q, prio_d;
    logic [5:0]  lcnt_q, lcnt_d;
    logic        ban0_q, ban0_d;
    logic        ban1_q, ban1_d;
    logic        lock_err_q, lock_err_d;
    logic        elig0, elig1;
    logic        issue0, issue1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            prio_q     <= 1'b0;
            lcnt_q     <= 6'd0;
            ban0_q     <= 1'b0;
            ban1_q     <= 1'b0;
            lock_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            prio_q     <= prio_d;
            lcnt_q     <= lcnt_d;
            ban0_q     <= ban0_d;
            ban1_q     <= ban1_d;
            lock_err_q <= lock_err_d;
        end
    end

    // Grant: the owner alone while locked, otherwise round-robin among unbanned requesters.
    always_comb begin
        gnt0  = 1'b0;
        gnt1  = 1'b0;
        elig0 = req0 & ~ban0_q;
        elig1 = req1 & ~ban1_q;
        case (state_q)
            OWN0:    gnt0 = req0;
            OWN1:    gnt1 = req1;
            default: begin
                gnt0 = elig0 & (~elig1 | ~prio_q);
                gnt1 = elig1 & (~elig0 | prio_q);
            end
        endcase
    end

    assign issue0         = req0 & gnt0;
    assign issue1         = req1 & gnt1;
    assign sub_data_valid = issue0 | issue1;
    assign sub_data_in_a  = issue0 ? a0 : (issue1 ? a1 : 64'd0);
    assign sub_data_in_b  = issue0 ? b0 : (issue1 ? b1 : 64'd0);
    assign lock_err       = lock_err_q;

    always_comb begin
        state_d    = state_q;
        prio_d     = prio_q;
        lcnt_d     = lcnt_q;
        ban0_d     = ban0_q & lock0;
        ban1_d     = ban1_q & lock1;
        lock_err_d = 1'b0;
        if (issue0) begin
            prio_d = 1'b1;
        end else if (issue1) begin
            prio_d = 1'b0;
        end
        case (state_q)
            IDLE: begin
                if (issue0 && lock0) begin
                    state_d = OWN0;
                    lcnt_d  = 6'd1;
                end else if (issue1 && lock1) begin
                    state_d = OWN1;
                    lcnt_d  = 6'd1;
                end
            end
            OWN0: begin
                if (!lock0) begin
                    state_d = IDLE;
                    lcnt_d  = 6'd0;
                end else if (lcnt_q < MAX_LCNT) begin
                    lcnt_d = lcnt_q + 6'd1;
                end else begin
                    // Watchdog: revoke, ban until the owner releases lock, hand priority over.
                    state_d    = IDLE;
                    lcnt_d     = 6'd0;
                    lock_err_d = 1'b1;
                    ban0_d     = 1'b1;
                    prio_d     = 1'b1;
                end
            end
            OWN1: begin
                if (!lock1) begin
                    state_d = IDLE;
                    lcnt_d  = 6'd0;
                end else if (lcnt_q < MAX_LCNT) begin
                    lcnt_d = lcnt_q + 6'd1;
                end else begin
                    state_d    = IDLE;
                    lcnt_d     = 6'd0;
                    lock_err_d = 1'b1;
                    ban1_d     = 1'b1;
                    prio_d     = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                lcnt_d  = 6'd0;
            end
        endcase
    end

`ifdef SUB64_ARB_RESULT_REG_EN
    logic [62:0] y0_q, y0_d, y1_q, y1_d;
    logic        y0v_q, y1v_q;

    assign y0_d = issue0 ? sub_data_out : y0_q;
    assign y1_d = issue1 ? sub_data_out : y1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y0_q  <= 63'd0;
            y1_q  <= 63'd0;
            y0v_q <= 1'b0;
            y1v_q <= 1'b0;
        end else begin
            y0_q  <= y0_d;
            y1_q  <= y1_d;
            y0v_q <= issue0;
            y1v_q <= issue1;
        end
    end

    assign y0       = y0_q;
    assign y1       = y1_q;
    assign y0_valid = y0v_q;
    assign y1_valid = y1v_q;
`else
    assign y0       = sub_data_out;
    assign y1       = sub_data_out;
    assign y0_valid = issue0;
    assign y1_valid = issue1;
`endif

endmodule

// File: tb/tb_sub64_share_arb.sv
// Directed bench for sub64_share_arb: default instance plus a MAX_LOCK=4 instance for the watchdog.
module tb_sub64_share_arb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0, lock0 = 1'b0, lock1 = 1'b0;
    logic [63:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;

    logic        gnt0, gnt1, y0v, y1v, lerr, sv;
    logic [62:0] y0, y1, so;
    logic [63:0] sa, sb, diff;

    logic        wgnt0, wgnt1, wy0v, wy1v, wlerr, wsv;
    logic [62:0] wy0, wy1, wso;
    logic [63:0] wsa, wsb, wdiff;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    // SUB64 model: 64-bit difference truncated to 63 bits.
    assign diff  = sa - sb;
    assign so    = diff[62:0];
    assign wdiff = wsa - wsb;
    assign wso   = wdiff[62:0];

    sub64_share_arb dut (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1), .gnt0(gnt0), .gnt1(gnt1), .y0(y0), .y1(y1),
        .y0_valid(y0v), .y1_valid(y1v), .lock_err(lerr), .sub_data_in_a(sa),
        .sub_data_in_b(sb), .sub_data_valid(sv), .sub_data_out(so)
    );

    sub64_share_arb #(.MAX_LOCK(4)) dut_wd (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1), .gnt0(wgnt0), .gnt1(wgnt1), .y0(wy0), .y1(wy1),
        .y0_valid(wy0v), .y1_valid(wy1v), .lock_err(wlerr), .sub_data_in_a(wsa),
        .sub_data_in_b(wsb), .sub_data_valid(wsv), .sub_data_out(wso)
    );

    task automatic idle_inputs();
        req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #3;
        nvec++; if (lerr !== 1'b0) begin nerr++; $display("FAIL reset_lock_err got %b want 0", lerr); end
        nvec++; if ({gnt0, gnt1, sv} !== 3'b000) begin nerr++; $display("FAIL reset_idle_grants got %b want 000", {gnt0, gnt1, sv}); end
        req0 = 1'b1; req1 = 1'b1;
        #1;
        nvec++; if ({gnt0, gnt1} !== 2'b10) begin nerr++; $display("FAIL reset_comb_grant got %b want 10", {gnt0, gnt1}); end
        apply_reset();
    endtask

    task automatic test_single_op();
        req1 = 1'b1; a1 = 64'h0000_0000_0000_0010; b1 = 64'h3;
        #4;
        nvec++; if ({gnt0, gnt1, sv} !== 3'b011) begin nerr++; $display("FAIL single_grant got %b want 011", {gnt0, gnt1, sv}); end
        nvec++; if (sa !== 64'h10 || sb !== 64'h3) begin nerr++; $display("FAIL single_operands got %h/%h want 10/3", sa, sb); end
`ifndef SUB64_ARB_RESULT_REG_EN
        nvec++; if (y1 !== 63'hD || y1v !== 1'b1) begin nerr++; $display("FAIL single_result got %h/%b want d/1", y1, y1v); end
`endif
        next_cycle();
        req1 = 1'b0;
        #4;
`ifdef SUB64_ARB_RESULT_REG_EN
        nvec++; if (y1 !== 63'hD || y1v !== 1'b1) begin nerr++; $display("FAIL single_result got %h/%b want d/1", y1, y1v); end
        next_cycle();
        #4;
        nvec++; if (y1 !== 63'hD || y1v !== 1'b0) begin nerr++; $display("FAIL single_hold got %h/%b want d/0", y1, y1v); end
`else
        nvec++; if (y1v !== 1'b0 || sv !== 1'b0) begin nerr++; $display("FAIL single_after got %b/%b want 0/0", y1v, sv); end
`endif
        next_cycle();
    endtask

    task automatic test_contention();
        logic [63:0] exp_a;
        apply_reset();
        a0 = 64'h100; b0 = 64'h1; a1 = 64'h200; b1 = 64'h2;
        for (int i = 0; i < 4; i++) begin
            req0 = 1'b1; req1 = 1'b1;
            exp_a = (i % 2 == 0) ? 64'h100 : 64'h200;
            #4;
            nvec++; if (gnt0 !== (i % 2 == 0) || gnt1 !== (i % 2 == 1)) begin nerr++; $display("FAIL contention_grant[%0d] got %b%b want %b%b", i, gnt0, gnt1, (i % 2 == 0), (i % 2 == 1)); end
            nvec++; if (sa !== exp_a) begin nerr++; $display("FAIL contention_in_a[%0d] got %h want %h", i, sa, exp_a); end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_lock();
        int n_gnt0 = 0;
        int n_iss1 = 0;
        apply_reset();
        req0 = 1'b1;
        #4;
        nvec++; if (gnt0 !== 1'b1) begin nerr++; $display("FAIL lock_prep got %b want 1", gnt0); end
        next_cycle();
        for (int i = 0; i < 26; i++) begin
            req0 = 1'b1; req1 = 1'b1; lock1 = 1'b1;
            #4;
            if (gnt0) n_gnt0++;
            if (gnt1 && sv) n_iss1++;
            next_cycle();
        end
        nvec++; if (n_gnt0 !== 0) begin nerr++; $display("FAIL lock_gnt0_blocked got %0d want 0", n_gnt0); end
        nvec++; if (n_iss1 !== 26) begin nerr++; $display("FAIL lock_port1_issues got %0d want 26", n_iss1); end
        lock1 = 1'b0; req1 = 1'b0;
        #4;
        nvec++; if (gnt0 !== 1'b0) begin nerr++; $display("FAIL lock_drop_cycle got %b want 0", gnt0); end
        next_cycle();
        #4;
        nvec++; if (gnt0 !== 1'b1) begin nerr++; $display("FAIL lock_handover got %b want 1", gnt0); end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_watchdog();
        int n_own = 0;
        int n_err = 0;
        int n_g0 = 0;
        int n_g1 = 0;
        apply_reset();
        req1 = 1'b1; lock1 = 1'b1;
        #4;
        nvec++; if (wgnt1 !== 1'b1 || wsv !== 1'b1) begin nerr++; $display("FAIL wd_first_grant got %b/%b want 1/1", wgnt1, wsv); end
        next_cycle();
        req0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #4;
            if (wgnt1 && !wgnt0) n_own++;
            if (wlerr) n_err++;
            next_cycle();
        end
        nvec++; if (n_own !== 4 || n_err !== 0) begin nerr++; $display("FAIL wd_owned_cycles got %0d/%0d want 4/0", n_own, n_err); end
        #4;
        nvec++; if ({wlerr, wgnt0, wgnt1} !== 3'b110) begin nerr++; $display("FAIL wd_expire got %b want 110", {wlerr, wgnt0, wgnt1}); end
        next_cycle();
        n_err = 0;
        for (int i = 0; i < 4; i++) begin
            #4;
            if (wlerr) n_err++;
            if (wgnt0) n_g0++;
            if (wgnt1) n_g1++;
            next_cycle();
        end
        nvec++; if (n_err !== 0 || n_g0 !== 4 || n_g1 !== 0) begin nerr++; $display("FAIL wd_banned got err=%0d g0=%0d g1=%0d want 0/4/0", n_err, n_g0, n_g1); end
        lock1 = 1'b0;
        #4;
        nvec++; if (wgnt1 !== 1'b0) begin nerr++; $display("FAIL wd_ban_release_cycle got %b want 0", wgnt1); end
        next_cycle();
        #4;
        nvec++; if ({wlerr, wgnt0, wgnt1} !== 3'b001) begin nerr++; $display("FAIL wd_unbanned got %b want 001", {wlerr, wgnt0, wgnt1}); end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_reset_mid_lock();
        apply_reset();
        req1 = 1'b1; lock1 = 1'b1; a1 = 64'h55; b1 = 64'h5;
        next_cycle();
        req0 = 1'b1;
        #2;
        nvec++; if ({gnt0, gnt1} !== 2'b01) begin nerr++; $display("FAIL midlock_owned got %b want 01", {gnt0, gnt1}); end
        rst_n = 1'b0;
        #1;
        nvec++; if ({gnt0, gnt1, lerr} !== 3'b100) begin nerr++; $display("FAIL midlock_in_reset got %b want 100", {gnt0, gnt1, lerr}); end
`ifdef SUB64_ARB_RESULT_REG_EN
        nvec++; if (y0 !== 63'd0 || y1 !== 63'd0 || y0v !== 1'b0 || y1v !== 1'b0) begin nerr++; $display("FAIL midlock_yreg got %h %h %b %b want 0 0 0 0", y0, y1, y0v, y1v); end
`endif
        @(posedge clk);
        #1 rst_n = 1'b1;
        #3;
        nvec++; if ({gnt0, gnt1} !== 2'b10) begin nerr++; $display("FAIL midlock_after got %b want 10", {gnt0, gnt1}); end
`ifdef SUB64_ARB_RESULT_REG_EN
        nvec++; if (y0v !== 1'b0 || y1v !== 1'b0) begin nerr++; $display("FAIL midlock_valid got %b%b want 00", y0v, y1v); end
`endif
        next_cycle();
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_contention();
        test_lock();
        test_watchdog();
        test_reset_mid_lock();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
